// File: rtl/serial_deserializer.sv
// Start/stop framed serial receiver: samples ser_in on bit_en strobes, assembles
// N data bits LSB-first, and presents good words with a one-cycle load strobe.
module serial_deserializer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         bit_en,
    input  logic         ser_in,
    output logic [N-1:0] data_out,
    output logic         load,
    output logic         frame_err,
    output logic         busy
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_shift;
    logic [N-1:0]    r_data;
    logic            r_load;
    logic            r_ferr;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [N-1:0]    w_shift_nxt;
    logic [N-1:0]    w_data_nxt;
    logic            w_load_nxt;
    logic            w_ferr_nxt;
    logic [N-1:0]    w_shift_in;

    // New sample enters at the MSB so the first data bit ends up in bit 0.
    assign w_shift_in = (r_shift >> 1) | (N'(ser_in) << (N - 1));

    // State, counter and data registers; clear wins over everything.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_load  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_load  <= w_load_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    // Next-state and strobe logic; without bit_en everything holds.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_load_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bit_en && !ser_in) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_en) begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_en) begin
                    w_state_nxt = IDLE;
                    if (ser_in) begin
                        w_data_nxt = r_shift;
                        w_load_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign data_out  = r_data;
    assign load      = r_load;
    assign frame_err = r_ferr;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: table of directed frames, hand sequences for
// clear/idle corners, and random frames against a queue-based frame model.
module tb_serial_deserializer;

    localparam int unsigned N = 8;

    logic         clk;
    logic         clear;
    logic         bit_en;
    logic         ser_in;
    logic [N-1:0] data_out;
    logic         load;
    logic         frame_err;
    logic         busy;

    serial_deserializer #(.N(N)) dut (
        .clk       (clk),
        .clear     (clear),
        .bit_en    (bit_en),
        .ser_in    (ser_in),
        .data_out  (data_out),
        .load      (load),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bits collected since the start bit of the current frame.
    logic         mq[$];
    logic [N-1:0] m_data;
    logic         m_load;
    logic         m_ferr;
    int           load_cnt;
    int           ferr_cnt;

    typedef struct {
        logic [7:0] word;
        logic       stop;
        int         gap;
        int         exp_loads;
        int         exp_ferrs;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic be, input logic si);
        logic [N-1:0] w;
        m_load = 1'b0;
        m_ferr = 1'b0;
        if (be) begin
            if (mq.size() == 0) begin
                if (!si) mq.push_back(si);
            end else begin
                mq.push_back(si);
                if (mq.size() == N + 2) begin
                    for (int i = 0; i < N; i++) w[i] = mq[i + 1];
                    if (si) begin
                        m_data = w;
                        m_load = 1'b1;
                    end else begin
                        m_ferr = 1'b1;
                    end
                    mq.delete();
                end
            end
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_data = '0;
        m_load = 1'b0;
        m_ferr = 1'b0;
    endtask

    // One clock: drive at negedge, compare just after posedge, then glitch ser_in.
    task automatic cycle(input logic be, input logic si);
        bit_en = be;
        ser_in = si;
        @(posedge clk);
        #1;
        model_step(be, si);
        check("data_out", 32'(data_out), 32'(m_data));
        check("load", 32'(load), 32'(m_load));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        check("busy", 32'(busy), 32'(mq.size() != 0));
        if (load) load_cnt++;
        if (frame_err) ferr_cnt++;
        ser_in = 1'($urandom);
        @(negedge clk);
    endtask

    task automatic gaps(input int n);
        for (int g = 0; g < n; g++) cycle(1'b0, 1'($urandom));
    endtask

    task automatic send_frame(input logic [N-1:0] word, input logic stop, input int gap);
        cycle(1'b1, 1'b0);
        gaps(gap);
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, word[i]);
            gaps(gap);
        end
        cycle(1'b1, stop);
        gaps(gap);
    endtask

    // Asynchronous clear in the middle of the low phase, checked before any edge.
    task automatic async_clear();
        #2;
        clear = 1'b1;
        #1;
        model_reset();
        check("clr_data", 32'(data_out), 32'h0);
        check("clr_load", 32'(load), 32'h0);
        check("clr_ferr", 32'(frame_err), 32'h0);
        check("clr_busy", 32'(busy), 32'h0);
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        tbl[0] = '{word: 8'hA5, stop: 1'b1, gap: 0, exp_loads: 1, exp_ferrs: 0, exp_data: 8'hA5};
        tbl[1] = '{word: 8'h3C, stop: 1'b0, gap: 0, exp_loads: 0, exp_ferrs: 1, exp_data: 8'hA5};
        tbl[2] = '{word: 8'h5A, stop: 1'b1, gap: 2, exp_loads: 1, exp_ferrs: 0, exp_data: 8'h5A};
        tbl[3] = '{word: 8'h01, stop: 1'b1, gap: 0, exp_loads: 1, exp_ferrs: 0, exp_data: 8'h01};
        tbl[4] = '{word: 8'h80, stop: 1'b1, gap: 0, exp_loads: 1, exp_ferrs: 0, exp_data: 8'h80};

        clear  = 1'b1;
        bit_en = 1'b0;
        ser_in = 1'b1;
        model_reset();
        load_cnt = 0;
        ferr_cnt = 0;
        #3;
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_load", 32'(load), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        clear = 1'b0;

        // Ten idle samples keep the receiver idle.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
        check("idle_busy", 32'(busy), 32'h0);

        // Directed frames, sent back-to-back in table order.
        for (int t = 0; t < 5; t++) begin
            load_cnt = 0;
            ferr_cnt = 0;
            send_frame(tbl[t].word, tbl[t].stop, tbl[t].gap);
            check("tbl_loads", 32'(load_cnt), 32'(tbl[t].exp_loads));
            check("tbl_ferrs", 32'(ferr_cnt), 32'(tbl[t].exp_ferrs));
            check("tbl_data", 32'(data_out), 32'(tbl[t].exp_data));
            check("tbl_busy", 32'(busy), 32'h0);
        end

        // Clear with a word held in data_out.
        async_clear();

        // Clear after four data bits, then a full 0xFF frame.
        load_cnt = 0;
        ferr_cnt = 0;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'($urandom));
        check("mid_busy", 32'(busy), 32'h1);
        async_clear();
        cycle(1'b1, 1'b1);
        check("post_clr_busy", 32'(busy), 32'h0);
        send_frame(8'hFF, 1'b1, 0);
        check("abort_loads", 32'(load_cnt), 32'h1);
        check("abort_ferrs", 32'(ferr_cnt), 32'h0);
        check("abort_data", 32'(data_out), 32'hFF);

        // Random frames, stop bits, strobe spacing and idle fill.
        for (int f = 0; f < 60; f++) begin
            send_frame(N'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
            for (int k = $urandom_range(0, 2); k > 0; k--) cycle(1'($urandom), 1'b1);
        end

        // Fully random line activity.
        for (int c = 0; c < 2000; c++) begin
            cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 4) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
